// File: rtl/peaks_reader.sv
// Captures each new peak frame into a FIFO and serves it to the host through a registered read port.
// Optional PEAKS_READER_TIMESTAMP_EN stores a free-running cycle count with every frame (address 14).
module peaks_reader #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 8,
  parameter int AMPL_WIDTH = 8,
  parameter int TIME_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [TIME_WIDTH-1:0]                 counter_in,
  input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]      freqs_in,
  input  logic [PEAKS-1:0][AMPL_WIDTH-1:0]      amplitudes_in,
  input  logic                                  chipselect,
  input  logic                                  read,
  input  logic [3:0]                            address,
  output logic [31:0]                           readdata,
  output logic                                  irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_TIME   = 4'd1;
  localparam logic [3:0] ADDR_TSTAMP = 4'd14;
  localparam logic [3:0] ADDR_POP    = 4'd15;

  logic [TIME_WIDTH-1:0]             s1_cnt, s2_cnt, last_cnt;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0]  s1_freqs, s2_freqs;
  logic [PEAKS-1:0][AMPL_WIDTH-1:0]  s1_amps, s2_amps;

  logic [TIME_WIDTH-1:0]             mem_time  [DEPTH];
  logic [PEAKS-1:0][FREQ_WIDTH-1:0]  mem_freqs [DEPTH];
  logic [PEAKS-1:0][AMPL_WIDTH-1:0]  mem_amps  [DEPTH];

  logic [AW:0]   wr_ptr, rd_ptr, occupancy;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full;
  logic          overflow;
  logic [7:0]    drop_count;

  logic          rd_strobe, status_rd, pop, new_frame, push, drop;
  logic [31:0]   status_word, rd_val;

`ifdef PEAKS_READER_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] mem_ts [DEPTH];
`endif

  function automatic logic [15:0] sext16(input logic [AMPL_WIDTH-1:0] a);
    logic [15:0] ext;
    ext = {16{a[AMPL_WIDTH-1]}};
    ext[AMPL_WIDTH-1:0] = a;
    return ext;
  endfunction

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign rd_strobe = chipselect && read;
  assign status_rd = rd_strobe && (address == ADDR_STATUS);
  assign pop       = rd_strobe && (address == ADDR_POP) && !empty;

  // A frame is new once the counter has been stable for two samples and differs from the last capture.
  assign new_frame = (s1_cnt == s2_cnt) && (s2_cnt != last_cnt);
  assign push      = new_frame && (!full || pop);
  assign drop      = new_frame && full && !pop;

  assign status_word = {8'd0, drop_count, 8'(occupancy), 5'd0, overflow, full, empty};

  always_comb begin
    rd_val = '0;
    if (address == ADDR_STATUS) begin
      rd_val = status_word;
    end else if (!empty) begin
      if (address == ADDR_TIME || address == ADDR_POP)
        rd_val = 32'(mem_time[rd_idx]);
      for (int j = 0; j < PEAKS; j++) begin
        if (address == 4'(j + 2))
          rd_val = {sext16(mem_amps[rd_idx][j]), 16'(mem_freqs[rd_idx][j])};
      end
`ifdef PEAKS_READER_TIMESTAMP_EN
      if (address == ADDR_TSTAMP)
        rd_val = mem_ts[rd_idx];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_cnt     <= '0;
      s2_cnt     <= '0;
      s1_freqs   <= '0;
      s2_freqs   <= '0;
      s1_amps    <= '0;
      s2_amps    <= '0;
      last_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      s1_cnt   <= counter_in;
      s1_freqs <= freqs_in;
      s1_amps  <= amplitudes_in;
      s2_cnt   <= s1_cnt;
      s2_freqs <= s1_freqs;
      s2_amps  <= s1_amps;
      irq      <= !empty;

      if (new_frame)
        last_cnt <= s2_cnt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      // A drop in the same cycle as a STATUS read survives the clear.
      if (drop) begin
        overflow <= 1'b1;
        if (status_rd)
          drop_count <= 8'd1;
        else if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (status_rd) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end

      if (rd_strobe)
        readdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_idx]  <= s2_cnt;
      mem_freqs[wr_idx] <= s2_freqs;
      mem_amps[wr_idx]  <= s2_amps;
`ifdef PEAKS_READER_TIMESTAMP_EN
      mem_ts[wr_idx]    <= cycle_cnt;
`endif
    end
  end

`ifdef PEAKS_READER_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule
